// File: rtl/prio_enc8_3_pkg.sv
// rtl/prio_enc8_3_pkg.sv - shared types, sizes and helpers for the priority encoder
package prio_enc_pkg;

    localparam int NUM_SRC = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } enc_state_t;

    function automatic logic [NUM_SRC-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [NUM_SRC-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc8_3_if.sv
// rtl/prio_enc8_3_if.sv - valid/ready code handshake between encoder and dispatcher
interface prio_enc8_3_if
    import prio_enc_pkg::*;
    ();

    logic              code_valid;
    logic [CODE_W-1:0] code;
    logic              code_ready;

    modport master (
        output code_valid,
        output code,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code,
        output code_ready
    );

endinterface

// File: rtl/prio_enc8_3_enc.sv
// rtl/prio_enc8_3_enc.sv - combinational highest-index-wins encoder over the pending vector
module prio_enc8
    import prio_enc_pkg::*;
(
    input  logic [NUM_SRC-1:0] pend_i,
    output logic [CODE_W-1:0]  idx_o,
    output logic               any_o
);

    // Ascending scan so the last hit, the highest index, wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_i[i]) begin
                idx_o = CODE_W'(i);
            end
        end
    end

    assign any_o = |pend_i;

endmodule

// File: rtl/prio_enc8_3.sv
// rtl/prio_enc8_3.sv - registered 8-to-3 priority encoder with event capture and handshake
module prio_enc8_3
    import prio_enc_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_SRC-1:0] req,
    prio_enc8_3_if.master      code_if,
    output logic [NUM_SRC-1:0] pend,
    output logic               overflow
);

    enc_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] req_q;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               overflow_q, overflow_d;

    logic [NUM_SRC-1:0] set_v;
    logic [NUM_SRC-1:0] clr_v;
    logic [CODE_W-1:0]  enc_idx;
    logic               enc_any;
    logic               accept;

    prio_enc8 u_enc (
        .pend_i (pend_q),
        .idx_o  (enc_idx),
        .any_o  (enc_any)
    );

    assign accept = (state_q == PRESENT) && code_if.code_ready;
    assign set_v  = en ? (EDGE_MODE ? (req & ~req_q) : req) : '0;
    assign clr_v  = accept ? onehot8(code_q) : '0;

    // Set is OR-ed after the clear so an event landing on the accepted line survives.
    assign pend_d     = (pend_q & ~clr_v) | set_v;
    assign overflow_d = |(set_v & pend_q & ~clr_v);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    code_d  = enc_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (code_if.code_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            req_q      <= '0;
            code_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            req_q      <= req;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign code_if.code_valid = (state_q == PRESENT);
    assign code_if.code       = code_q;
    assign pend               = pend_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_prio_enc8_3.sv
// tb/tb_prio_enc8_3.sv - directed self-checking bench for prio_enc8_3 in edge and level mode
module tb_prio_enc8_3;

    logic       clk;
    logic       rst;
    logic       en_e, en_l;
    logic [7:0] req_e, req_l;
    logic [7:0] pend_e, pend_l;
    logic       ovf_e, ovf_l;

    int checks;
    int failures;

    prio_enc8_3_if cif_e ();
    prio_enc8_3_if cif_l ();

    prio_enc8_3 #(.EDGE_MODE(1'b1)) dut_e (
        .clk      (clk),
        .rst      (rst),
        .en       (en_e),
        .req      (req_e),
        .code_if  (cif_e),
        .pend     (pend_e),
        .overflow (ovf_e)
    );

    prio_enc8_3 #(.EDGE_MODE(1'b0)) dut_l (
        .clk      (clk),
        .rst      (rst),
        .en       (en_l),
        .req      (req_l),
        .code_if  (cif_l),
        .pend     (pend_l),
        .overflow (ovf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        en_e             = 1'b1;
        req_e            = 8'hFF;
        cif_e.code_ready = 1'b0;
        en_l             = 1'b0;
        req_l            = 8'h00;
        cif_l.code_ready = 1'b0;

        // Reset held with requests high
        step();
        step();
        chk("rst_valid", cif_e.code_valid, 1'b0);
        chk("rst_code", cif_e.code, 3'd0);
        chk("rst_pend", pend_e, 8'h00);
        chk("rst_ovf", ovf_e, 1'b0);
        chk("rst_pend_lvl", pend_l, 8'h00);

        // Release with req still high: counts as an edge
        rst = 1'b0;
        step();
        chk("rel_pend", pend_e, 8'hFF);
        chk("rel_valid", cif_e.code_valid, 1'b0);
        req_e            = 8'h00;
        cif_e.code_ready = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            step();
            chk("drain_valid", cif_e.code_valid, 1'b1);
            chk("drain_code", cif_e.code, k);
            step();
            chk("drain_gap", cif_e.code_valid, 1'b0);
        end
        chk("drain_pend", pend_e, 8'h00);

        // Single event on source 5
        req_e = 8'h20;
        step();
        req_e = 8'h00;
        chk("single_pend", pend_e, 8'h20);
        chk("single_early", cif_e.code_valid, 1'b0);
        step();
        chk("single_valid", cif_e.code_valid, 1'b1);
        chk("single_code", cif_e.code, 3'b101);
        step();
        chk("single_drop", cif_e.code_valid, 1'b0);
        chk("single_pend0", pend_e, 8'h00);

        // Simultaneous events 7, 4, 1
        req_e = 8'b1001_0010;
        step();
        req_e = 8'h00;
        chk("sim_pend", pend_e, 8'h92);
        step();
        chk("sim_v7", cif_e.code_valid, 1'b1);
        chk("sim_c7", cif_e.code, 3'd7);
        step();
        chk("sim_g7", cif_e.code_valid, 1'b0);
        step();
        chk("sim_v4", cif_e.code_valid, 1'b1);
        chk("sim_c4", cif_e.code, 3'd4);
        step();
        chk("sim_g4", cif_e.code_valid, 1'b0);
        step();
        chk("sim_v1", cif_e.code_valid, 1'b1);
        chk("sim_c1", cif_e.code, 3'd1);
        step();
        chk("sim_g1", cif_e.code_valid, 1'b0);
        chk("sim_pend0", pend_e, 8'h00);

        // Backpressure and overflow
        cif_e.code_ready = 1'b0;
        req_e = 8'h04;
        step();
        req_e = 8'h00;
        step();
        chk("bp_valid", cif_e.code_valid, 1'b1);
        chk("bp_code", cif_e.code, 3'd2);
        chk("bp_ovf0", ovf_e, 1'b0);
        req_e = 8'h04;
        step();
        req_e = 8'h00;
        chk("bp_ovf_pulse", ovf_e, 1'b1);
        step();
        chk("bp_ovf_clear", ovf_e, 1'b0);
        req_e = 8'h40;
        step();
        req_e = 8'h00;
        chk("bp_nopreempt", cif_e.code, 3'd2);
        chk("bp_hold_valid", cif_e.code_valid, 1'b1);
        chk("bp_pend", pend_e, 8'h44);
        chk("bp_ovf_new", ovf_e, 1'b0);
        cif_e.code_ready = 1'b1;
        step();
        chk("bp_acc_valid", cif_e.code_valid, 1'b0);
        chk("bp_acc_pend", pend_e, 8'h40);
        step();
        chk("bp_v6", cif_e.code_valid, 1'b1);
        chk("bp_c6", cif_e.code, 3'd6);
        step();
        chk("bp_end_pend", pend_e, 8'h00);

        // Level mode with enable gating
        req_l = 8'h08;
        step();
        step();
        chk("lvl_gated_pend", pend_l, 8'h00);
        chk("lvl_gated_valid", cif_l.code_valid, 1'b0);
        en_l = 1'b1;
        step();
        chk("lvl_pend", pend_l, 8'h08);
        step();
        chk("lvl_v3", cif_l.code_valid, 1'b1);
        chk("lvl_c3", cif_l.code, 3'd3);
        cif_l.code_ready = 1'b1;
        step();
        chk("lvl_acc_valid", cif_l.code_valid, 1'b0);
        chk("lvl_reset_pend", pend_l, 8'h08);
        chk("lvl_no_ovf", ovf_l, 1'b0);
        step();
        chk("lvl_again_v", cif_l.code_valid, 1'b1);
        chk("lvl_again_c", cif_l.code, 3'd3);

        // Set/clear collision on source 4
        cif_e.code_ready = 1'b0;
        req_e = 8'h10;
        step();
        req_e = 8'h00;
        step();
        chk("col_v4", cif_e.code_valid, 1'b1);
        chk("col_c4", cif_e.code, 3'd4);
        cif_e.code_ready = 1'b1;
        req_e = 8'h10;
        step();
        req_e = 8'h00;
        chk("col_drop", cif_e.code_valid, 1'b0);
        chk("col_pend", pend_e, 8'h10);
        chk("col_ovf", ovf_e, 1'b0);
        step();
        chk("col_again_v", cif_e.code_valid, 1'b1);
        chk("col_again_c", cif_e.code, 3'd4);
        step();
        chk("col_end_pend", pend_e, 8'h00);

        // Async reset mid-present
        cif_e.code_ready = 1'b0;
        req_e = 8'h01;
        step();
        req_e = 8'h00;
        step();
        chk("mid_valid", cif_e.code_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", cif_e.code_valid, 1'b0);
        chk("mid_rst_pend", pend_e, 8'h00);
        chk("mid_rst_code", cif_e.code, 3'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
